// File: rtl/tdfc_stream_queue4.sv
// tdfc_stream_queue4: four-entry elastic buffer for a _d/_e/_v/_b token stream.
// Each entry holds {end-of-stream flag, data}, so the flag travels with its
// token. Back-pressure and valid come only from the registered count, which
// keeps the upstream and downstream handshakes free of combinational paths.
module tdfc_stream_queue4 #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_d,
   input  logic             in_e,
   input  logic             in_v,
   output logic             in_b,
   output logic [WIDTH-1:0] out_d,
   output logic             out_e,
   output logic             out_v,
   input  logic             out_b,
   output logic [2:0]       level
);

   localparam int DEPTH = 4;

   logic [WIDTH:0] mem [DEPTH];
   logic [1:0]     wr_ptr;
   logic [1:0]     rd_ptr;
   logic [2:0]     count;
   logic [2:0]     count_next;
   logic           push;
   logic           pop;
   logic [WIDTH:0] head;

   // Handshake decode: flags come from the registered count only.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      in_b  = 1'b0;
      out_v = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
      head  = mem[rd_ptr];
      in_b  = (count == 3'd4);
      out_v = (count != 3'd0);
      push  = in_v && !in_b;
      pop   = out_v && !out_b;
   end

   // Next occupancy: a simultaneous push and pop leaves the count unchanged.
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + 3'd1;
         2'b01:   count_next = count - 3'd1;
         default: count_next = count;
      endcase
   end

   // Pointer and count registers; pointers wrap 3->0 through 2-bit overflow.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         count <= count_next;
      end
   end

   // Token storage, cleared on reset so the outputs read zero while held in reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // NOTE: the storage is deliberately reset so out_d/out_e show zero, not stale tokens, during reset.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= {in_e, in_d};
      end
   end

   assign out_d = head[WIDTH-1:0];
   assign out_e = head[WIDTH];
   assign level = count;

endmodule

// File: tb/tb_tdfc_stream_queue4.sv
// Bench for tdfc_stream_queue4: directed scenarios plus randomized traffic,
// compared against a queue-based model of an ideal four-token buffer.
module tb_tdfc_stream_queue4;

   localparam int W = 8;

   logic         clock;
   logic         reset;
   logic [W-1:0] in_d;
   logic         in_e;
   logic         in_v;
   logic         in_b;
   logic [W-1:0] out_d;
   logic         out_e;
   logic         out_v;
   logic         out_b;
   logic [2:0]   level;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: the stored tokens, tokens accepted, tokens observed leaving.
   logic [W:0] model [$];
   logic [W:0] sent  [$];
   logic [W:0] got   [$];

   tdfc_stream_queue4 #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .in_d  (in_d),
      .in_e  (in_e),
      .in_v  (in_v),
      .in_b  (in_b),
      .out_d (out_d),
      .out_e (out_e),
      .out_v (out_v),
      .out_b (out_b),
      .level (level)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge; the model decides transfers from its own occupancy.
   task automatic tick();
      bit         do_push;
      bit         do_pop;
      logic [W:0] obs;
      logic [W:0] tmp;
      do_push = in_v && (model.size() < 4);
      do_pop  = !out_b && (model.size() != 0);
      obs     = {out_e, out_d};
      @(posedge clock);
      if (do_pop) begin
         tmp = model.pop_front();
         got.push_back(obs);
      end
      if (do_push) begin
         model.push_back({in_e, in_d});
         sent.push_back({in_e, in_d});
      end
      #1;
   endtask

   task automatic clear_model();
      model.delete();
      sent.delete();
      got.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1; in_v = 1'b0; in_d = '0; in_e = 1'b0; out_b = 1'b0;
      #1 reset = 1'b0;
      #1;
      n_total++; if (level !== 3'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
      n_total++; if (in_b !== 1'b0) $display("FAIL reset_in_b: got %b want 0", in_b); else n_pass++;
      n_total++; if (out_v !== 1'b0) $display("FAIL reset_out_v: got %b want 0", out_v); else n_pass++;
      n_total++; if (out_d !== '0) $display("FAIL reset_out_d: got %h want 00", out_d); else n_pass++;
      n_total++; if (out_e !== 1'b0) $display("FAIL reset_out_e: got %b want 0", out_e); else n_pass++;
      // A valid token offered across an edge while reset is held must not be taken.
      in_v = 1'b1; in_d = 8'hAB; in_e = 1'b1;
      @(posedge clock);
      #1;
      n_total++; if (level !== 3'd0) $display("FAIL reset_hold_level: got %0d want 0", level); else n_pass++;
      n_total++; if (out_v !== 1'b0) $display("FAIL reset_hold_out_v: got %b want 0", out_v); else n_pass++;
      n_total++; if (out_d !== '0) $display("FAIL reset_hold_out_d: got %h want 00", out_d); else n_pass++;
      in_v = 1'b0;
      #2 reset = 1'b1;
      clear_model();
   endtask

   task automatic test_fill();
      logic [W-1:0] v;
      clear_model();
      out_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         v = 8'(8'h11 * (i + 1));
         in_v = 1'b1; in_d = v; in_e = 1'b0;
         tick();
         n_total++; if (level !== 3'(i + 1)) $display("FAIL fill_level[%0d]: got %0d want %0d", i, level, i + 1); else n_pass++;
         n_total++; if (in_b !== (i == 3)) $display("FAIL fill_in_b[%0d]: got %b want %b", i, in_b, (i == 3)); else n_pass++;
         n_total++; if (out_v !== 1'b1 || out_d !== 8'h11) $display("FAIL fill_head[%0d]: got v=%b d=%h want v=1 d=11", i, out_v, out_d); else n_pass++;
      end
      in_d = 8'h55;
      tick();
      n_total++; if (level !== 3'd4) $display("FAIL fill_held_level: got %0d want 4", level); else n_pass++;
      n_total++; if (in_b !== 1'b1) $display("FAIL fill_held_in_b: got %b want 1", in_b); else n_pass++;
      n_total++; if (out_d !== 8'h11) $display("FAIL fill_held_head: got %h want 11", out_d); else n_pass++;
   endtask

   task automatic test_drain();
      logic [W-1:0] heads [5];
      heads[0] = 8'h11; heads[1] = 8'h22; heads[2] = 8'h33; heads[3] = 8'h44; heads[4] = 8'h55;
      out_b = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n_total++; if (out_v !== 1'b1 || out_d !== heads[k]) $display("FAIL drain_head[%0d]: got v=%b d=%h want v=1 d=%h", k, out_v, out_d, heads[k]); else n_pass++;
         tick();
         if (k == 0) begin
            n_total++; if (in_b !== 1'b0 || level !== 3'd3) $display("FAIL drain_unblock: got in_b=%b level=%0d want in_b=0 level=3", in_b, level); else n_pass++;
         end
         if (k == 1) begin
            // 0x55 enters on the same edge that pops 0x22, so the level holds.
            n_total++; if (level !== 3'd3) $display("FAIL drain_accept_55: got level %0d want 3", level); else n_pass++;
            in_v = 1'b0;
         end
      end
      n_total++; if (out_v !== 1'b0 || level !== 3'd0) $display("FAIL drain_empty: got v=%b level=%0d want v=0 level=0", out_v, level); else n_pass++;
      n_total++; if (got.size() != 5) $display("FAIL drain_count: got %0d tokens want 5", got.size()); else n_pass++;
      for (int k = 0; k < got.size() && k < 5; k++) begin
         n_total++; if (got[k] !== {1'b0, heads[k]}) $display("FAIL drain_order[%0d]: got %h want %h", k, got[k], {1'b0, heads[k]}); else n_pass++;
      end
   endtask

   task automatic test_streaming();
      clear_model();
      in_v = 1'b1; out_b = 1'b0; in_e = 1'b0;
      for (int i = 0; i < 16; i++) begin
         in_d = 8'(i);
         tick();
         n_total++; if (level !== 3'd1 || out_v !== 1'b1 || out_d !== 8'(i)) $display("FAIL stream[%0d]: got level=%0d v=%b d=%h want level=1 v=1 d=%h", i, level, out_v, out_d, 8'(i)); else n_pass++;
      end
      in_v = 1'b0;
      tick();
      n_total++; if (level !== 3'd0) $display("FAIL stream_tail_level: got %0d want 0", level); else n_pass++;
      n_total++; if (got.size() != 16) $display("FAIL stream_count: got %0d tokens want 16", got.size()); else n_pass++;
      for (int i = 0; i < got.size() && i < 16; i++) begin
         n_total++; if (got[i] !== 9'(i)) $display("FAIL stream_order[%0d]: got %h want %h", i, got[i], 9'(i)); else n_pass++;
      end
   endtask

   task automatic test_eos();
      clear_model();
      out_b = 1'b0;
      in_v = 1'b1; in_d = 8'hA0; in_e = 1'b0;
      tick();
      n_total++; if (out_d !== 8'hA0 || out_e !== 1'b0) $display("FAIL eos_a0: got d=%h e=%b want d=a0 e=0", out_d, out_e); else n_pass++;
      in_d = 8'hA1; in_e = 1'b1;
      tick();
      n_total++; if (out_d !== 8'hA1 || out_e !== 1'b1) $display("FAIL eos_a1: got d=%h e=%b want d=a1 e=1", out_d, out_e); else n_pass++;
      // Data and flag on an invalid cycle must be ignored.
      in_v = 1'b0; in_d = 8'hEE; in_e = 1'b1;
      tick();
      tick();
      n_total++; if (out_v !== 1'b0 || level !== 3'd0) $display("FAIL eos_ignore: got v=%b level=%0d want v=0 level=0", out_v, level); else n_pass++;
      n_total++; if (got.size() != 2 || got[0] !== 9'h0A0 || got[1] !== 9'h1A1) $display("FAIL eos_seq: got %0d tokens first=%h want 2 tokens 0a0,1a1", got.size(), (got.size() > 0) ? got[0] : 9'h0); else n_pass++;
      in_e = 1'b0;
   endtask

   task automatic test_wrap();
      clear_model();
      for (int c = 0; c < 40; c++) begin
         in_v  = 1'($urandom_range(0, 1));
         in_d  = 8'($urandom);
         in_e  = 1'($urandom_range(0, 1));
         out_b = ($urandom_range(0, 3) == 0);
         tick();
         n_total++; if (level !== 3'(model.size()) || level > 3'd4) $display("FAIL wrap_level[%0d]: got %0d want %0d", c, level, model.size()); else n_pass++;
         n_total++; if (in_b !== (model.size() == 4) || out_v !== (model.size() != 0)) $display("FAIL wrap_flags[%0d]: got in_b=%b v=%b want size %0d", c, in_b, out_v, model.size()); else n_pass++;
         if (model.size() != 0) begin
            n_total++; if ({out_e, out_d} !== model[0]) $display("FAIL wrap_head[%0d]: got %h want %h", c, {out_e, out_d}, model[0]); else n_pass++;
         end
      end
      in_v = 1'b0; out_b = 1'b0;
      for (int c = 0; c < 8 && model.size() != 0; c++) begin
         tick();
      end
      n_total++; if (level !== 3'd0 || model.size() != 0) $display("FAIL wrap_drain: got level %0d want 0", level); else n_pass++;
      n_total++; if (got.size() != sent.size()) $display("FAIL wrap_count: got %0d tokens want %0d", got.size(), sent.size()); else n_pass++;
      for (int i = 0; i < got.size() && i < sent.size(); i++) begin
         n_total++; if (got[i] !== sent[i]) $display("FAIL wrap_order[%0d]: got %h want %h", i, got[i], sent[i]); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      clear_model();
      out_b = 1'b1; in_e = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_v = 1'b1; in_d = 8'(8'h31 + i);
         tick();
      end
      in_v = 1'b0;
      n_total++; if (level !== 3'd3) $display("FAIL mid_pre_level: got %0d want 3", level); else n_pass++;
      #3 reset = 1'b0;
      #1;
      n_total++; if (level !== 3'd0 || out_v !== 1'b0 || in_b !== 1'b0) $display("FAIL mid_async: got level=%0d v=%b in_b=%b want 0,0,0", level, out_v, in_b); else n_pass++;
      n_total++; if (out_d !== '0 || out_e !== 1'b0) $display("FAIL mid_async_data: got d=%h e=%b want 00,0", out_d, out_e); else n_pass++;
      in_v = 1'b1; in_d = 8'h99; out_b = 1'b0;
      @(posedge clock);
      #1;
      n_total++; if (level !== 3'd0 || out_v !== 1'b0 || out_d !== '0) $display("FAIL mid_held: got level=%0d v=%b d=%h want 0,0,00", level, out_v, out_d); else n_pass++;
      in_v = 1'b0;
      clear_model();
      #2 reset = 1'b1;
      in_v = 1'b1; in_d = 8'h7E; out_b = 1'b1;
      tick();
      n_total++; if (level !== 3'd1 || out_d !== 8'h7E) $display("FAIL mid_first: got level=%0d d=%h want 1,7e", level, out_d); else n_pass++;
      in_v = 1'b0; out_b = 1'b0;
      tick();
      n_total++; if (got.size() != 1 || got[0] !== 9'h07E || level !== 3'd0) $display("FAIL mid_out: got %0d tokens level=%0d want one 07e, level 0", got.size(), level); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_streaming();
      test_eos();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
